sm3_eng_arb: RTL

- Round-robin arbiter and sequencer that shares one SM3 hash engine (padder/expander feeding the compression core) among NREQ requesters.
- Granularity is one whole message:
  - The grant is held from the first accepted word until the last word is accepted.
  - The arbiter then waits for the engine's 256-bit result and returns it tagged with the requester ID.
- Sits between the per-master SM3 request ports and the single SM3 engine instance.

---
 rtl/sm3_eng_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sm3_eng_arb.sv
// sm3_eng_arb: round-robin sharing of one SM3 engine among NREQ masters.
// Grants a whole message, then waits for the digest and returns it tagged.
module sm3_eng_arb #(
   parameter int          NREQ    = 4,
   parameter int          IDW     = 2,
   parameter logic [15:0] TMO_CYC = 16'd1023
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ*64-1:0]   req_dat_i,
   input  logic [NREQ-1:0]      req_vld_i,
   input  logic [NREQ-1:0]      req_lst_i,
   output logic [NREQ-1:0]      req_rdy_o,
   output logic [63:0]          eng_inpt_dat_o,
   output logic                 eng_inpt_vld_o,
   output logic                 eng_inpt_lst_o,
   input  logic                 eng_inpt_rdy_i,
   input  logic [255:0]         eng_res_i,
   input  logic                 eng_res_vld_i,
   output logic [255:0]         res_o,
   output logic                 res_vld_o,
   output logic [IDW-1:0]       res_id_o,
   output logic                 res_err_o,
   output logic                 busy_o
);

   localparam int IW = IDW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [255:0]     res_q, res_d;
   logic             res_vld_q, res_vld_d;
   logic [IDW-1:0]   res_id_q, res_id_d;
   logic             res_err_q, res_err_d;

   logic [IW-1:0]    idx;
   logic [IDW-1:0]   pick_id;
   logic             pick_vld;
   logic             g_vld;
   logic             g_lst;
   logic [63:0]      g_dat;
   logic             tmo;

   // Round-robin search starting just after the last completed requester
   always_comb begin
      idx      = '0;
      pick_id  = '0;
      pick_vld = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = {1'b0, rr_ptr_q} + IW'(i);
         if (idx >= IW'(NREQ)) begin
            idx = idx - IW'(NREQ);
         end
         if (!pick_vld && req_vld_i[idx[IDW-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = idx[IDW-1:0];
         end
      end
   end

   // Signals of the currently granted requester
   always_comb begin
      g_vld = req_vld_i[gnt_id_q];
      g_lst = req_lst_i[gnt_id_q];
      g_dat = req_dat_i[{gnt_id_q, 6'd0} +: 64];
      tmo   = (cnt_q == (TMO_CYC - 16'd1));
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers: grant, fairness pointer, wait counter, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_id_q  <= '0;
         rr_ptr_q  <= IDW'(NREQ - 1);
         cnt_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
         res_id_q  <= '0;
         res_err_q <= 1'b0;
      end else begin
         gnt_id_q  <= gnt_id_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
         res_id_q  <= res_id_d;
         res_err_q <= res_err_d;
      end
   end

   // Next-state and register update logic
   always_comb begin
      state_d   = state_q;
      gnt_id_d  = gnt_id_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      res_id_d  = res_id_q;
      res_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_id_d = pick_id;
               state_d  = XFER;
            end
         end
         XFER: begin
            if (g_vld && eng_inpt_rdy_i && g_lst) begin
               rr_ptr_d = gnt_id_q;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + 16'd1;
            // A digest arriving on the timeout cycle still counts as success
            if (eng_res_vld_i) begin
               res_d     = eng_res_i;
               res_vld_d = 1'b1;
               res_id_d  = gnt_id_q;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (tmo) begin
               res_err_d = 1'b1;
               res_id_d  = gnt_id_q;
               cnt_d     = '0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic: zero-latency forwarding of the granted port in XFER
   always_comb begin
      req_rdy_o      = '0;
      eng_inpt_dat_o = '0;
      eng_inpt_vld_o = 1'b0;
      eng_inpt_lst_o = 1'b0;
      if (state_q == XFER) begin
         eng_inpt_dat_o      = g_dat;
         eng_inpt_vld_o      = g_vld;
         eng_inpt_lst_o      = g_lst & g_vld;
         req_rdy_o[gnt_id_q] = eng_inpt_rdy_i;
      end
   end

   assign res_o     = res_q;
   assign res_vld_o = res_vld_q;
   assign res_id_o  = res_id_q;
   assign res_err_o = res_err_q;
   assign busy_o    = (state_q != IDLE);

endmodule
